// File: rtl/router_fifo.sv
//-----------------------------------------------------------------------------
// router_fifo
//   Per-destination-port packet FIFO of a byte-oriented router. Each entry
//   holds {header flag, payload byte}. Reads have one cycle of latency:
//   data_out is registered. An internal 6-bit packet counter tracks how many
//   bytes of the current packet are still to be read. This covers the payload
//   length from the header plus one parity byte.
//
// Parameters
//   DATA_WIDTH : payload byte width. Must be at least 8 because the header
//                length field is data[7:2].
//   DEPTH      : number of entries. Must be a power of two.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   resetn     : asynchronous active-low reset
//   soft_reset : synchronous flush of this port (pointers, counter, data_out)
//   write_enb  : write strobe; ignored while full
//   read_enb   : read strobe; ignored while empty
//   lfd_state  : marks data_in as a header byte
//   data_in    : byte to store
//   data_out   : registered read data
//   full       : no free entry
//   empty      : no stored entry
//   fifo_count : occupancy 0..DEPTH. Present only when the macro
//                ROUTER_FIFO_OCCUPANCY_EN is defined.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module router_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    soft_reset,
  input  logic                    write_enb,
  input  logic                    read_enb,
  input  logic                    lfd_state,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty
`ifdef ROUTER_FIFO_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0]  fifo_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Storage is not reset. After either reset the pointers are equal, so stale
  // words can never be read out.
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [5:0]            pkt_cnt_q, pkt_cnt_d;

  logic                  wr_fire;
  logic                  rd_fire;
  logic [DATA_WIDTH:0]   rd_word;

  // Flags come straight from the registered pointers. The extra MSB tells a
  // full FIFO apart from an empty one when the index bits coincide.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  end

  // Writes and reads are qualified by the pre-edge flags. A simultaneous
  // read and write on a full FIFO therefore drops the write. On an empty FIFO
  // the read is dropped instead.
  always_comb begin
    wr_fire = write_enb & ~full  & ~soft_reset;
    rd_fire = read_enb  & ~empty & ~soft_reset;
    rd_word = mem[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    pkt_cnt_d  = pkt_cnt_q;

    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      data_out_d = '0;
      pkt_cnt_d  = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        data_out_d = rd_word[DATA_WIDTH-1:0];
        // A header reloads the counter with its length field plus one for
        // the parity byte. Other bytes count down and stop at zero.
        if (rd_word[DATA_WIDTH]) begin
          pkt_cnt_d = rd_word[7:2] + 6'd1;
        end else if (pkt_cnt_q != 6'd0) begin
          pkt_cnt_d = pkt_cnt_q - 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  assign data_out = data_out_q;

`ifdef ROUTER_FIFO_OCCUPANCY_EN
  // The pointer difference modulo 2*DEPTH is the occupancy. It is zero
  // whenever a reset has cleared both pointers.
  assign fifo_count = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
`timescale 1ns/1ps

module tb_router_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          soft_reset;
  logic          write_enb;
  logic          read_enb;
  logic          lfd_state;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
`ifdef ROUTER_FIFO_OCCUPANCY_EN
  logic [$clog2(DEPTH):0] fifo_count;
`endif

  router_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    ,
    .fifo_count (fifo_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of stored {header, byte} words, the
  // packet counter value, and the last byte that was read out.
  logic [DW:0]   mq[$];
  logic [DW-1:0] exp_q[$];   // scoreboard: bytes expected on data_out
  logic [5:0]    m_pkt;
  logic [DW-1:0] m_hold;
  bit            mon_en;

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_pkt  = 6'd0;
    m_hold = '0;
  endtask

  // Advance the model by one clock edge. The flags are taken from the state
  // before the edge.
  task automatic model_step();
    bit          was_full;
    bit          was_empty;
    logic [DW:0] w;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (soft_reset) begin
      mq.delete();
      m_pkt = 6'd0;
      exp_q.push_back('0);
    end else begin
      if (read_enb && !was_empty) begin
        w = mq.pop_front();
        if (w[DW]) m_pkt = w[7:2] + 6'd1;
        else if (m_pkt != 0) m_pkt = m_pkt - 6'd1;
        exp_q.push_back(w[DW-1:0]);
      end
      if (write_enb && !was_full) mq.push_back({lfd_state, data_in});
    end
  endtask

  // The driver is called at posedge+1. It applies the inputs for one cycle,
  // then steps the model at the edge.
  task automatic cyc(input logic we, input logic re, input logic lfd,
                     input logic [DW-1:0] d, input logic sr);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = d;
    soft_reset = sr;
    @(posedge clk);
    model_step();
    #1;
    if (we || re || sr)
      $display("t=%0t we=%0b re=%0b lfd=%0b din=%02h sr=%0b model_size=%0d",
               $time, we, re, lfd, d, sr, mq.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Monitor: it runs on the falling edge, away from the active edge. A byte
  // in the scoreboard means the DUT presented a read result this cycle.
  // Otherwise data_out must hold its last value.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        m_hold = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(m_hold));
      end else begin
        chk("data_hold", 32'(data_out), 32'(m_hold));
      end
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("pkt_cnt", 32'(dut.pkt_cnt_q), 32'(m_pkt));
`ifdef ROUTER_FIFO_OCCUPANCY_EN
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
`endif
    end
  end

  task automatic hard_reset_pulse();
    @(posedge clk);
    #3;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    soft_reset = 1'b0;
    resetn     = 1'b0;
    model_clear();
    #1;
    // The reset takes effect immediately, before any clock edge.
    chk("arst_data_out", 32'(data_out), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_full", 32'(full), 32'h0);
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    chk("arst_fifo_count", 32'(fifo_count), 32'h0);
`endif
    $display("t=%0t resetn pulse", $time);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  logic [DW-1:0] seq [DEPTH];

  initial begin
    checks     = 0;
    errors     = 0;
    mon_en     = 1'b0;
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = '0;
    model_clear();

    // Power-on reset state.
    #20;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    #30;
    resetn = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Header 0D (length 3), three payload bytes, then the parity byte.
    cyc(1, 0, 1, 8'h0D, 0);
    cyc(1, 0, 0, 8'hA1, 0);
    cyc(1, 0, 0, 8'hA2, 0);
    cyc(1, 0, 0, 8'hA3, 0);
    cyc(1, 0, 0, 8'hFF, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);                     // read while empty: dropped
    idle(1);

    // Fill the FIFO. A 17th write while full is dropped. Then drain it.
    for (int i = 0; i < DEPTH; i++) begin
      seq[i] = DW'($urandom);
      cyc(1, 0, 0, seq[i], 0);
    end
    cyc(1, 0, 0, 8'h55, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, '0, 0);
    idle(1);

    // Full FIFO with a simultaneous read and write: the read wins.
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, (i == 0), DW'($urandom), 0);
    cyc(1, 1, 0, 8'h77, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, '0, 0);

    // Empty FIFO with a simultaneous read and write: the write wins.
    cyc(1, 1, 0, 8'h3C, 0);
    cyc(0, 1, 0, '0, 0);

    // A soft reset with a write in the same cycle: the flush wins.
    cyc(1, 0, 1, 8'h11, 0);
    cyc(1, 0, 0, 8'h22, 0);
    cyc(1, 0, 0, 8'h33, 0);
    cyc(0, 1, 0, '0, 0);
    cyc(1, 0, 0, 8'h44, 1);
    cyc(0, 1, 0, '0, 0);
    idle(1);

    // Occupancy: five writes, then two reads.
    for (int i = 0; i < 5; i++) cyc(1, 0, (i == 0), DW'(8'h80 + i), 0);
    cyc(0, 1, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);
    // Asynchronous reset in the middle of a packet.
    hard_reset_pulse();
    cyc(1, 0, 0, 8'h5A, 0);                  // first edge after release
    cyc(0, 1, 0, '0, 0);

    // Randomised traffic: a write-heavy phase, then a read-heavy phase.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 300; i++) begin
        logic we;
        logic re;
        logic lfd;
        logic sr;
        we  = ($urandom_range(0, 99) < (ph == 0 ? 70 : 35));
        re  = ($urandom_range(0, 99) < (ph == 0 ? 35 : 70));
        lfd = ($urandom_range(0, 7) == 0);
        sr  = ($urandom_range(0, 99) < 2);
        cyc(we, re, lfd, DW'($urandom), sr);
      end
      hard_reset_pulse();
    end

    idle(3);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload byte width.
REQ-002 Parameter DEPTH, default 16, storage entries; power of two only.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 soft_reset  input  1  synchronous per-port flush from the synchronizer's sreset_x.
REQ-006 write_enb  input  1  write strobe; one bit of the synchronizer's write_enb bus.
REQ-007 read_enb  input  1  read strobe; the destination port's ren.
REQ-008 lfd_state  input  1  high when data_in is a header byte.
REQ-009 data_in  input  DATA_WIDTH  byte to store.
REQ-010 data_out  output  DATA_WIDTH  registered read data.
REQ-011 full  output  1  no free entry; feeds the synchronizer's fullx.
REQ-012 empty  output  1  no stored entry; feeds the synchronizer's emptyx.

Function
REQ-013 The block SHALL store DEPTH words, each DATA_WIDTH+1 bits: {lfd_state, data_in}.
REQ-014 Write and read pointers SHALL be log2(DEPTH)+1 bits; the MSB is the wrap bit; increments wrap modulo 2*DEPTH.
REQ-015 empty SHALL be 1 when both pointers are equal, combinational from registered pointers.
REQ-016 full SHALL be 1 when the index bits match and the wrap bits differ, combinational from registered pointers.
REQ-017 A write SHALL occur when write_enb=1 and full=0: store {lfd_state, data_in} at the write index, then increment the write pointer.
REQ-018 write_enb=1 while full=1 SHALL be ignored, leaving contents and pointers unchanged.
REQ-019 A read SHALL occur when read_enb=1 and empty=0: data_out <= stored byte on the next edge (1-cycle latency), then increment the read pointer.
REQ-020 read_enb=1 while empty=1 SHALL leave data_out and pointers unchanged.
REQ-021 full and empty SHALL be sampled before the edge for simultaneous read and write:
- when full, the read proceeds and the write is dropped;
- when empty, the write proceeds and the read is dropped;
- otherwise both proceed and occupancy is unchanged.
REQ-022 A 6-bit packet counter SHALL load payload_length+1 when a read word has header bit=1.
- payload_length = stored data[7:2]; the +1 covers the parity byte.
REQ-023 The packet counter SHALL decrement on each read of a non-header word while nonzero, and SHALL saturate at 0.
REQ-024 soft_reset=1 SHALL, at the next edge, clear both pointers, the packet counter and data_out to 0, with priority over a same-cycle read or write.
REQ-025 Memory contents SHALL NOT be cleared by either reset; empty=1 after reset makes them unobservable.

Reset
REQ-026 resetn=0 SHALL immediately, without a clock, force pointers=0, packet counter=0, data_out=0, empty=1, full=0.
REQ-027 Deassertion of resetn SHALL be synchronous to clk; the first write is accepted on the first edge with resetn=1.
REQ-028 resetn asserted mid-packet SHALL discard all stored words and any partial packet state.

Configuration
REQ-029 Macro ROUTER_FIFO_OCCUPANCY_EN, when defined, SHALL add output fifo_count (log2(DEPTH)+1 bits).
- fifo_count = write pointer minus read pointer, modulo 2*DEPTH; range 0..DEPTH.
- fifo_count SHALL be 0 under resetn or soft_reset.
REQ-030 Without ROUTER_FIFO_OCCUPANCY_EN, the fifo_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset: resetn=0 at t=0, released at 50 ns -> data_out=8'h00, empty=1, full=0 before the first edge.
REQ-032 Write header 8'h0D (lfd=1, length 3), then 8'hA1, 8'hA2, 8'hA3, 8'hFF -> empty=0.
- Five reads SHALL return 0D, A1, A2, A3, FF, each one cycle after its read_enb.
- The packet counter SHALL go 4,3,2,1,0; empty=1 after the fifth read.
REQ-033 16 consecutive writes -> full=1 after the 16th; a 17th write (8'h55) is dropped; 16 reads return the original sequence; empty=1.
REQ-034 With the FIFO full, read_enb=1 and write_enb=1 in the same cycle -> one word read, incoming word dropped, full=0 next cycle.
REQ-035 Write 3 words, then soft_reset=1 for one cycle while write_enb=1 -> empty=1, data_out=8'h00, subsequent read returns nothing new.
REQ-036 With ROUTER_FIFO_OCCUPANCY_EN defined: 5 writes then 2 reads -> fifo_count 5 then 3; resetn pulse -> fifo_count=0.
